spi_master: RTL and testbench

SPI bus master that pairs with the team's SPI slave. A CPU-side register interface loads a transmit word, runs one full-duplex transfer of `DATA_W` bits (mode 0, LSB first), and returns the received word with a ready flag and an optional interrupt. Before each frame it issues one preamble SCLK pulse with `ss` high, so the slave can latch its transmit word on that falling edge.

---
 rtl/spi_master_if.sv | 31 +++
 rtl/spi_master.sv | 148 ++++++++++++++
 tb/tb_spi_master.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_if.sv
// CPU-side register bus of the SPI master.
//   data_in   : write data from the CPU
//   data_out  : read data to the CPU (combinational from address)
//   address   : register select
//   sel       : access strobe
//   read      : read qualifier
//   write     : write qualifier
//   interrupt : int_en & ready
// The master modport is the CPU, the slave modport is the spi_master block.
interface spi_master_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
);
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic [ADDR_W-1:0] address;
  logic              sel;
  logic              read;
  logic              write;
  logic              interrupt;

  modport master (
    output data_in, address, sel, read, write,
    input  data_out, interrupt
  );

  modport slave (
    input  data_in, address, sel, read, write,
    output data_out, interrupt
  );
endinterface

// File: rtl/spi_master.sv
// SPI master, mode 0, LSB first, one full-duplex DATA_W-bit frame per TX write.
// A preamble SCLK pulse with ss high precedes every frame so the attached
// slave can latch its transmit word on that falling edge.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   sclk : SPI clock, idles low
//   ss   : slave select, active low
//   mosi : master out
//   miso : slave out, sampled in the first cycle of each SCLK high phase
//   bus  : CPU register interface (TX=0, RX=1, STATUS=2, INT_EN=3, SOFT_RST=4)
module spi_master #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 3,
  parameter int CLK_DIV = 2
) (
  input  logic         clk,
  input  logic         rst,
  output logic         sclk,
  output logic         ss,
  output logic         mosi,
  input  logic         miso,
  spi_master_if.slave  bus
);

  localparam int BCNT_W = $clog2(DATA_W) + 1;
  localparam int HCNT_W = $clog2(CLK_DIV) + 1;
  localparam logic [HCNT_W-1:0] H_LAST = HCNT_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, PRE_H, PRE_L, SETUP, BIT_H, BIT_L, HOLD} state_t;

  state_t            state, state_nxt;
  logic [HCNT_W-1:0] hcnt;
  logic [BCNT_W-1:0] bcnt;
  logic [DATA_W-1:0] tx_sh, rx_sh, rx_reg;
  logic              ready, overrun, int_en;
  logic              busy, start, half_done, last_bit, hold_done, entering;
  logic              wr_tx, wr_int, wr_srst, rd_rx, rd_stat;

  // Register access decode.
  assign wr_tx   = bus.sel && bus.write && (bus.address == ADDR_W'(0));
  assign rd_rx   = bus.sel && bus.read  && (bus.address == ADDR_W'(1));
  assign rd_stat = bus.sel && bus.read  && (bus.address == ADDR_W'(2));
  assign wr_int  = bus.sel && bus.write && (bus.address == ADDR_W'(3));
  assign wr_srst = bus.sel && bus.write && (bus.address == ADDR_W'(4));

  assign busy      = (state != IDLE);
  assign start     = wr_tx && !busy;
  assign half_done = (hcnt == '0);
  assign last_bit  = (bcnt == BCNT_W'(DATA_W));
  assign entering  = (state_nxt != state);
  // Soft reset in the last HOLD cycle aborts the frame, so nothing is delivered.
  assign hold_done = (state == HOLD) && half_done && !wr_srst;

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = PRE_H;
      PRE_H:   if (half_done) state_nxt = PRE_L;
      PRE_L:   if (half_done) state_nxt = SETUP;
      SETUP:   if (half_done) state_nxt = BIT_H;
      BIT_H:   if (half_done) state_nxt = BIT_L;
      BIT_L:   if (half_done) state_nxt = last_bit ? HOLD : BIT_H;
      HOLD:    if (half_done) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
    // Soft reset aborts the frame; outputs follow from the IDLE target below.
    if (wr_srst) state_nxt = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // sclk/ss are decoded from the next state and registered, so they change
  // exactly on state entry and never glitch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sclk  <= 1'b0;
      ss    <= 1'b1;
      mosi  <= 1'b0;
      hcnt  <= '0;
      bcnt  <= '0;
    end else begin
      state <= state_nxt;
      sclk  <= (state_nxt == PRE_H) || (state_nxt == BIT_H);
      ss    <= (state_nxt == IDLE) || (state_nxt == PRE_H) || (state_nxt == PRE_L);
      if (entering)          hcnt <= H_LAST;
      else if (!half_done)   hcnt <= hcnt - 1'b1;
      if (entering) begin
        case (state_nxt)
          SETUP: begin
            mosi <= tx_sh[0];
            bcnt <= '0;
          end
          BIT_L: begin
            mosi <= tx_sh[1];
            bcnt <= bcnt + 1'b1;
          end
          IDLE:    mosi <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  // NOTE: the shift registers are pure datapath: they are fully loaded or
  // fully shifted before any bit of them is used, so they carry no reset.
  always_ff @(posedge clk) begin
    if (start)
      tx_sh <= bus.data_in;
    else if (entering && state_nxt == BIT_L)
      tx_sh <= tx_sh >> 1;
    if (state == BIT_H && hcnt == H_LAST)
      rx_sh <= {miso, rx_sh[DATA_W-1:1]};
  end

  // CPU-visible registers; soft reset leaves them untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_reg  <= '0;
      ready   <= 1'b0;
      overrun <= 1'b0;
      int_en  <= 1'b0;
    end else begin
      if (hold_done) rx_reg <= rx_sh;
      // Set wins over a same-cycle clear for both sticky flags.
      if (hold_done)  ready <= 1'b1;
      else if (rd_rx) ready <= 1'b0;
      if (wr_tx && busy) overrun <= 1'b1;
      else if (rd_stat)  overrun <= 1'b0;
      if (wr_int) int_en <= bus.data_in[0];
    end
  end

  always_comb begin
    bus.data_out = '0;
    case (bus.address)
      ADDR_W'(1): bus.data_out = rx_reg;
      ADDR_W'(2): bus.data_out = {{(DATA_W-3){1'b0}}, overrun, busy, ready};
      ADDR_W'(3): bus.data_out = {{(DATA_W-1){1'b0}}, int_en};
      default:    bus.data_out = '0;
    endcase
  end

  assign bus.interrupt = int_en & ready;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: dut1 runs with CLK_DIV=2 (loopback or a
// behavioural mode-0 slave on miso), dut2 with CLK_DIV=1 in loopback.
module tb_spi_master;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic sclk1, ss1, mosi1, miso1;
  logic sclk2, ss2, mosi2;
  logic use_slave = 1'b0;

  spi_master_if #(.DATA_W(32), .ADDR_W(3)) bus1 ();
  spi_master_if #(.DATA_W(32), .ADDR_W(3)) bus2 ();

  spi_master #(.DATA_W(32), .ADDR_W(3), .CLK_DIV(2)) dut1 (
    .clk(clk), .rst(rst), .sclk(sclk1), .ss(ss1), .mosi(mosi1), .miso(miso1), .bus(bus1)
  );

  spi_master #(.DATA_W(32), .ADDR_W(3), .CLK_DIV(1)) dut2 (
    .clk(clk), .rst(rst), .sclk(sclk2), .ss(ss2), .mosi(mosi2), .miso(mosi2), .bus(bus2)
  );

  // Behavioural mode-0 slave: loads on the preamble fall, shifts on falls,
  // samples mosi on rises while selected.
  logic [31:0] slave_tx = 32'h0;
  logic [31:0] s_sh = 32'h0;
  logic [31:0] s_rx = 32'h0;
  logic        s_miso = 1'b0;
  int          s_done = 0;

  always @(negedge sclk1) begin
    if (ss1) begin
      s_sh   = slave_tx;
      s_miso = slave_tx[0];
    end else begin
      s_sh   = s_sh >> 1;
      s_miso = s_sh[0];
    end
  end
  always @(posedge sclk1) if (!ss1) s_rx = {mosi1, s_rx[31:1]};
  always @(posedge ss1) s_done++;

  assign miso1 = use_slave ? s_miso : mosi1;

  int sclk_rises = 0;
  int sclk_falls = 0;
  always @(posedge sclk1) sclk_rises++;
  always @(negedge sclk1) sclk_falls++;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    bus1.sel = 1'b0; bus1.read = 1'b0; bus1.write = 1'b0;
    bus2.sel = 1'b0; bus2.read = 1'b0; bus2.write = 1'b0;
  endtask

  task automatic bus_write(input int d, input logic [2:0] a, input logic [31:0] v);
    @(negedge clk);
    if (d == 1) begin
      bus1.address = a; bus1.data_in = v; bus1.sel = 1'b1; bus1.write = 1'b1;
    end else begin
      bus2.address = a; bus2.data_in = v; bus2.sel = 1'b1; bus2.write = 1'b1;
    end
    @(negedge clk);
    bus_idle();
  endtask

  task automatic bus_read(input int d, input logic [2:0] a, output logic [31:0] v);
    @(negedge clk);
    if (d == 1) begin
      bus1.address = a; bus1.sel = 1'b1; bus1.read = 1'b1;
    end else begin
      bus2.address = a; bus2.sel = 1'b1; bus2.read = 1'b1;
    end
    #1;
    v = (d == 1) ? bus1.data_out : bus2.data_out;
    @(negedge clk);
    bus_idle();
  endtask

  // Called right after bus_write returns; k counts clock edges after the
  // edge that accepted the write. Returns -1 if a bound expires.
  task automatic wait_frame(input int d, output int fall_k, output int rise_k);
    logic s;
    fall_k = -1;
    rise_k = -1;
    for (int k = 1; k <= 2000; k++) begin
      @(posedge clk);
      #1;
      s = (d == 1) ? ss1 : ss2;
      if (!s && fall_k < 0) fall_k = k;
      if (s && fall_k >= 0) begin
        rise_k = k;
        break;
      end
    end
  endtask

  logic [31:0] rd;
  int fk, rk, r0, f0, d0;

  initial begin
    bus_idle();
    bus1.address = '0; bus1.data_in = '0;
    bus2.address = '0; bus2.data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sclk", {31'b0, sclk1}, 32'd0);
    check("rst_ss", {31'b0, ss1}, 32'd1);
    check("rst_mosi", {31'b0, mosi1}, 32'd0);
    check("rst_irq", {31'b0, bus1.interrupt}, 32'd0);
    check("rst_ss2", {31'b0, ss2}, 32'd1);
    @(negedge clk);
    rst = 1'b1;

    // Loopback, H=2.
    r0 = sclk_rises; f0 = sclk_falls;
    bus_write(1, 3'd0, 32'hA5A5_1234);
    wait_frame(1, fk, rk);
    check("lb_ss_fall", fk, 32'd4);
    check("lb_ss_rise", rk, 32'd136);
    check("lb_rises", sclk_rises - r0, 32'd33);
    check("lb_falls", sclk_falls - f0, 32'd33);
    bus_read(1, 3'd2, rd); check("lb_status", rd, 32'd1);
    bus_read(1, 3'd1, rd); check("lb_rx", rd, 32'hA5A5_1234);
    bus_read(1, 3'd2, rd); check("lb_status_clr", rd, 32'd0);

    // Slave attached.
    use_slave = 1'b1;
    slave_tx  = 32'hDEAD_BEEF;
    d0 = s_done;
    bus_write(1, 3'd0, 32'h0F0F_00FF);
    wait_frame(1, fk, rk);
    check("sl_ss_rise", rk, 32'd136);
    bus_read(1, 3'd1, rd); check("sl_master_rx", rd, 32'hDEAD_BEEF);
    check("sl_slave_rx", s_rx, 32'h0F0F_00FF);
    check("sl_slave_done", s_done - d0, 32'd1);
    use_slave = 1'b0;

    // Overrun.
    bus_write(1, 3'd0, 32'h3C3C_5A5A);
    repeat (10) @(posedge clk);
    bus_write(1, 3'd0, 32'h1111_1111);
    wait_frame(1, fk, rk);
    check("ov_done", (rk > 0) ? 32'd1 : 32'd0, 32'd1);
    bus_read(1, 3'd2, rd); check("ov_status", rd, 32'd5);
    bus_read(1, 3'd2, rd); check("ov_status2", rd, 32'd1);
    bus_read(1, 3'd1, rd); check("ov_rx", rd, 32'h3C3C_5A5A);

    // Interrupt.
    bus_write(1, 3'd3, 32'd1);
    bus_read(1, 3'd3, rd); check("ie_read", rd, 32'd1);
    bus_write(1, 3'd0, 32'h0000_C0DE);
    wait_frame(1, fk, rk);
    check("irq_set", {31'b0, bus1.interrupt}, 32'd1);
    bus_read(1, 3'd1, rd); check("irq_rx", rd, 32'h0000_C0DE);
    check("irq_clr", {31'b0, bus1.interrupt}, 32'd0);
    bus_read(1, 3'd2, rd); check("irq_status", rd, 32'd0);

    // Soft reset during bit 10.
    bus_write(1, 3'd0, 32'h1234_5678);
    repeat (43) @(posedge clk);
    #1;
    check("sr_mid_ss", {31'b0, ss1}, 32'd0);
    bus_write(1, 3'd4, 32'd0);
    check("sr_ss", {31'b0, ss1}, 32'd1);
    check("sr_sclk", {31'b0, sclk1}, 32'd0);
    bus_read(1, 3'd2, rd); check("sr_status", rd, 32'd0);
    bus_read(1, 3'd1, rd); check("sr_rx", rd, 32'h0000_C0DE);
    bus_read(1, 3'd3, rd); check("sr_ie", rd, 32'd1);

    // Hard reset during bit 5.
    bus_write(1, 3'd0, 32'hFEDC_BA98);
    repeat (23) @(posedge clk);
    #2;
    check("hr_mid_ss", {31'b0, ss1}, 32'd0);
    rst = 1'b0;
    #1;
    check("hr_ss", {31'b0, ss1}, 32'd1);
    check("hr_sclk", {31'b0, sclk1}, 32'd0);
    check("hr_mosi", {31'b0, mosi1}, 32'd0);
    check("hr_irq", {31'b0, bus1.interrupt}, 32'd0);
    bus1.address = 3'd1; #1; check("hr_rx", bus1.data_out, 32'd0);
    bus1.address = 3'd2; #1; check("hr_status", bus1.data_out, 32'd0);
    bus1.address = 3'd3; #1; check("hr_ie", bus1.data_out, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    bus_write(1, 3'd0, 32'h0000_0001);
    wait_frame(1, fk, rk);
    check("hr_after_rise", rk, 32'd136);
    bus_read(1, 3'd1, rd); check("hr_after_rx", rd, 32'h0000_0001);

    // H=1 loopback on dut2.
    bus_write(2, 3'd0, 32'hFFFF_FFFF);
    wait_frame(2, fk, rk);
    check("h1_ss_fall", fk, 32'd2);
    check("h1_ss_rise", rk, 32'd68);
    bus_read(2, 3'd1, rd); check("h1_rx", rd, 32'hFFFF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
